// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Round-robin arbiter sharing one memory slave port between the
//                instruction-fetch and LSU masters, with a response watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned WORD_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  imem_valid_i,
   output logic                  imem_ready_o,
   input  logic [ADDR_WIDTH-1:0] imem_addr_i,
   input  logic [WORD_WIDTH-1:0] imem_wdata_i,
   input  logic [3:0]            imem_we_i,
   output logic [WORD_WIDTH-1:0] imem_rdata_o,
   input  logic                  dmem_valid_i,
   output logic                  dmem_ready_o,
   input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
   input  logic [WORD_WIDTH-1:0] dmem_wdata_i,
   input  logic [3:0]            dmem_we_i,
   output logic [WORD_WIDTH-1:0] dmem_rdata_o,
   output logic                  mem_valid_o,
   input  logic                  mem_ready_i,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [WORD_WIDTH-1:0] mem_wdata_o,
   output logic [3:0]            mem_we_o,
   input  logic [WORD_WIDTH-1:0] mem_rdata_i,
   output logic                  bus_err_o
);

   localparam logic [1:0]  c_st_idle  = 2'd0;
   localparam logic [1:0]  c_st_gnt_i = 2'd1;
   localparam logic [1:0]  c_st_gnt_d = 2'd2;
   localparam logic        c_lg_i     = 1'b0;
   localparam logic        c_lg_d     = 1'b1;
   localparam logic        c_wd_en    = (TIMEOUT_CYCLES != 0);
   localparam logic [15:0] c_wd_last  = 16'(TIMEOUT_CYCLES - 1);

   logic [1:0]  r_state;
   logic        r_last_grant;
   logic [15:0] r_wd_cnt;
   logic        r_bus_err;

   logic        w_gnt_i;
   logic        w_gnt_d;
   logic        w_cur_valid;
   logic        w_other_valid;
   logic        w_timeout;

   // Grants are masked during reset so an in-flight transfer is dropped at once.
   always_comb begin
      w_gnt_i       = (r_state == c_st_gnt_i) && !rst;
      w_gnt_d       = (r_state == c_st_gnt_d) && !rst;
      w_cur_valid   = (w_gnt_i && imem_valid_i) || (w_gnt_d && dmem_valid_i);
      w_other_valid = (r_state == c_st_gnt_i) ? dmem_valid_i : imem_valid_i;
      w_timeout     = c_wd_en && w_cur_valid && !mem_ready_i && (r_wd_cnt == c_wd_last);
   end

   always_comb begin
      mem_valid_o  = w_cur_valid && !w_timeout;
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
      mem_we_o     = '0;
      imem_ready_o = w_gnt_i && (mem_ready_i || w_timeout);
      dmem_ready_o = w_gnt_d && (mem_ready_i || w_timeout);
      imem_rdata_o = (w_gnt_i && !w_timeout) ? mem_rdata_i : '0;
      dmem_rdata_o = (w_gnt_d && !w_timeout) ? mem_rdata_i : '0;
      if (w_gnt_i) begin
         mem_addr_o  = imem_addr_i;
         mem_wdata_o = imem_wdata_i;
         mem_we_o    = imem_we_i;
      end else if (w_gnt_d) begin
         mem_addr_o  = dmem_addr_i;
         mem_wdata_o = dmem_wdata_i;
         mem_we_o    = dmem_we_i;
      end
   end

   assign bus_err_o = r_bus_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= c_st_idle;
         r_last_grant <= c_lg_d;
         r_wd_cnt     <= '0;
         r_bus_err    <= 1'b0;
      end else begin
         case (r_state)
            c_st_idle: begin
               r_wd_cnt <= '0;
               if (imem_valid_i && (!dmem_valid_i || r_last_grant == c_lg_d)) begin
                  r_state      <= c_st_gnt_i;
                  r_last_grant <= c_lg_i;
               end else if (dmem_valid_i) begin
                  r_state      <= c_st_gnt_d;
                  r_last_grant <= c_lg_d;
               end
            end
            c_st_gnt_i, c_st_gnt_d: begin
               if (mem_ready_i) begin
                  // Hand over straight to a waiting master to avoid an idle bubble.
                  r_wd_cnt <= '0;
                  if (w_other_valid) begin
                     r_state      <= (r_state == c_st_gnt_i) ? c_st_gnt_d : c_st_gnt_i;
                     r_last_grant <= (r_state == c_st_gnt_i) ? c_lg_d : c_lg_i;
                  end else begin
                     r_state <= c_st_idle;
                  end
               end else if (!w_cur_valid) begin
                  r_state  <= c_st_idle;
                  r_wd_cnt <= '0;
               end else if (w_timeout) begin
                  r_state   <= c_st_idle;
                  r_wd_cnt  <= '0;
                  r_bus_err <= 1'b1;
               end else begin
                  r_wd_cnt <= r_wd_cnt + 16'd1;
               end
            end
            default: begin
               r_state  <= c_st_idle;
               r_wd_cnt <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_arbiter
//  Description : Directed vector bench for mem_bus_arbiter (TIMEOUT_CYCLES=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

   logic        clk;
   logic        rst;
   logic        imem_valid_i, imem_ready_o;
   logic [31:0] imem_addr_i, imem_wdata_i, imem_rdata_o;
   logic [3:0]  imem_we_i;
   logic        dmem_valid_i, dmem_ready_o;
   logic [31:0] dmem_addr_i, dmem_wdata_i, dmem_rdata_o;
   logic [3:0]  dmem_we_i;
   logic        mem_valid_o, mem_ready_i;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic [3:0]  mem_we_o;
   logic        bus_err_o;

   int n_checks = 0;
   int n_errors = 0;

   mem_bus_arbiter #(
      .ADDR_WIDTH(32), .WORD_WIDTH(32), .TIMEOUT_CYCLES(4)
   ) dut (
      .clk(clk), .rst(rst),
      .imem_valid_i(imem_valid_i), .imem_ready_o(imem_ready_o), .imem_addr_i(imem_addr_i),
      .imem_wdata_i(imem_wdata_i), .imem_we_i(imem_we_i), .imem_rdata_o(imem_rdata_o),
      .dmem_valid_i(dmem_valid_i), .dmem_ready_o(dmem_ready_o), .dmem_addr_i(dmem_addr_i),
      .dmem_wdata_i(dmem_wdata_i), .dmem_we_i(dmem_we_i), .dmem_rdata_o(dmem_rdata_o),
      .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i),
      .bus_err_o(bus_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        iv;   logic [31:0] ia; logic [3:0] iwe; logic [31:0] iwd;
      logic        dv;   logic [31:0] da; logic [3:0] dwe; logic [31:0] dwd;
      logic        mrdy; logic [31:0] mrd;
      logic        e_mv; logic [31:0] e_ma; logic [3:0] e_mwe; logic [31:0] e_mwd;
      logic        e_irdy; logic [31:0] e_ird;
      logic        e_drdy; logic [31:0] e_drd;
      logic        e_err;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s row=%0d got=0x%08h expected=0x%08h", name, row, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic iv, input logic [31:0] ia, input logic dv,
                        input logic [31:0] da, input logic mrdy);
      @(posedge clk);
      #1;
      rst = r; imem_valid_i = iv; imem_addr_i = ia; dmem_valid_i = dv; dmem_addr_i = da;
      mem_ready_i = mrdy;
      imem_we_i = '0; imem_wdata_i = '0; dmem_we_i = '0; dmem_wdata_i = '0; mem_rdata_i = '0;
   endtask

   task automatic apply(input vec_t t, input int row);
      @(posedge clk);
      #1;
      rst = t.rst;
      imem_valid_i = t.iv; imem_addr_i = t.ia; imem_we_i = t.iwe; imem_wdata_i = t.iwd;
      dmem_valid_i = t.dv; dmem_addr_i = t.da; dmem_we_i = t.dwe; dmem_wdata_i = t.dwd;
      mem_ready_i = t.mrdy; mem_rdata_i = t.mrd;
      @(negedge clk);
      check("mem_valid",  row, 32'(mem_valid_o),  32'(t.e_mv));
      check("mem_addr",   row, mem_addr_o,        t.e_ma);
      check("mem_we",     row, 32'(mem_we_o),     32'(t.e_mwe));
      check("mem_wdata",  row, mem_wdata_o,       t.e_mwd);
      check("imem_ready", row, 32'(imem_ready_o), 32'(t.e_irdy));
      check("imem_rdata", row, imem_rdata_o,      t.e_ird);
      check("dmem_ready", row, 32'(dmem_ready_o), 32'(t.e_drdy));
      check("dmem_rdata", row, dmem_rdata_o,      t.e_drd);
      check("bus_err",    row, 32'(bus_err_o),    32'(t.e_err));
   endtask

   initial begin
      rst = 1'b1;
      imem_valid_i = 0; imem_addr_i = 0; imem_we_i = 0; imem_wdata_i = 0;
      dmem_valid_i = 0; dmem_addr_i = 0; dmem_we_i = 0; dmem_wdata_i = 0;
      mem_ready_i = 0; mem_rdata_i = 0;

      // rst, iv,ia,iwe,iwd, dv,da,dwe,dwd, mrdy,mrd, e_mv,e_ma,e_mwe,e_mwd, e_irdy,e_ird, e_drdy,e_drd, e_err
      // Single fetch
      tbl.push_back(vec_t'{1, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0});
      tbl.push_back(vec_t'{0, 1,'h100,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0});
      tbl.push_back(vec_t'{0, 1,'h100,0,0, 0,0,0,0, 0,0, 1,'h100,0,0, 0,0, 0,0, 0});
      tbl.push_back(vec_t'{0, 1,'h100,0,0, 0,0,0,0, 1,'hDEADBEEF, 1,'h100,0,0, 1,'hDEADBEEF, 0,0, 0});
      tbl.push_back(vec_t'{0, 0,0,0,0, 0,0,0,0, 0,'h12345678, 0,0,0,0, 0,0, 0,0, 0});
      // Simultaneous requests from reset: I first, then D write with no bubble
      tbl.push_back(vec_t'{1, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0});
      tbl.push_back(vec_t'{0, 1,0,0,0, 1,'h2000,'hF,'h55AA55AA, 0,0, 0,0,0,0, 0,0, 0,0, 0});
      tbl.push_back(vec_t'{0, 1,0,0,0, 1,'h2000,'hF,'h55AA55AA, 0,0, 1,0,0,0, 0,0, 0,0, 0});
      tbl.push_back(vec_t'{0, 1,0,0,0, 1,'h2000,'hF,'h55AA55AA, 1,'hA5A50001, 1,0,0,0, 1,'hA5A50001, 0,0, 0});
      tbl.push_back(vec_t'{0, 0,0,0,0, 1,'h2000,'hF,'h55AA55AA, 0,0, 1,'h2000,'hF,'h55AA55AA, 0,0, 0,0, 0});
      tbl.push_back(vec_t'{0, 0,0,0,0, 1,'h2000,'hF,'h55AA55AA, 1,'h11112222, 1,'h2000,'hF,'h55AA55AA, 0,0, 1,'h11112222, 0});
      tbl.push_back(vec_t'{0, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0});
      // Watchdog: D read, slave silent, forced completion on 4th granted cycle
      tbl.push_back(vec_t'{1, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0});
      tbl.push_back(vec_t'{0, 0,0,0,0, 1,'h300,0,0, 0,'hBADBAD00, 0,0,0,0, 0,0, 0,0, 0});
      tbl.push_back(vec_t'{0, 0,0,0,0, 1,'h300,0,0, 0,'hBADBAD00, 1,'h300,0,0, 0,0, 0,'hBADBAD00, 0});
      tbl.push_back(vec_t'{0, 0,0,0,0, 1,'h300,0,0, 0,'hBADBAD00, 1,'h300,0,0, 0,0, 0,'hBADBAD00, 0});
      tbl.push_back(vec_t'{0, 0,0,0,0, 1,'h300,0,0, 0,'hBADBAD00, 1,'h300,0,0, 0,0, 0,'hBADBAD00, 0});
      tbl.push_back(vec_t'{0, 0,0,0,0, 1,'h300,0,0, 0,'hBADBAD00, 0,'h300,0,0, 0,0, 1,0, 0});
      tbl.push_back(vec_t'{0, 1,'h104,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 1});
      tbl.push_back(vec_t'{0, 1,'h104,0,0, 0,0,0,0, 0,0, 1,'h104,0,0, 0,0, 0,0, 1});
      tbl.push_back(vec_t'{0, 1,'h104,0,0, 0,0,0,0, 1,'h0BADF00D, 1,'h104,0,0, 1,'h0BADF00D, 0,0, 1});
      tbl.push_back(vec_t'{0, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 1});
      // Reset mid-transfer in GNT_D with a slave ready in the reset cycle
      tbl.push_back(vec_t'{1, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 1});
      tbl.push_back(vec_t'{0, 0,0,0,0, 1,'h400,'h3,'h77, 0,0, 0,0,0,0, 0,0, 0,0, 0});
      tbl.push_back(vec_t'{0, 0,0,0,0, 1,'h400,'h3,'h77, 0,0, 1,'h400,'h3,'h77, 0,0, 0,0, 0});
      tbl.push_back(vec_t'{1, 0,0,0,0, 1,'h400,'h3,'h77, 1,'h99, 0,0,0,0, 0,0, 0,0, 0});
      tbl.push_back(vec_t'{0, 0,0,0,0, 0,0,0,0, 1,'h99, 0,0,0,0, 0,0, 0,0, 0});
      // Abandon: I drops valid after one granted cycle, pending D follows
      tbl.push_back(vec_t'{0, 1,'h500,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0});
      tbl.push_back(vec_t'{0, 1,'h500,0,0, 1,'h600,0,0, 0,0, 1,'h500,0,0, 0,0, 0,0, 0});
      tbl.push_back(vec_t'{0, 0,'h500,0,0, 1,'h600,0,0, 0,0, 0,'h500,0,0, 0,0, 0,0, 0});
      tbl.push_back(vec_t'{0, 0,0,0,0, 1,'h600,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0});
      tbl.push_back(vec_t'{0, 0,0,0,0, 1,'h600,0,0, 0,0, 1,'h600,0,0, 0,0, 0,0, 0});
      tbl.push_back(vec_t'{0, 0,0,0,0, 1,'h600,0,0, 1,'h66, 1,'h600,0,0, 0,0, 1,'h66, 0});
      tbl.push_back(vec_t'{0, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0});

      foreach (tbl[i]) apply(tbl[i], i);

      // Fairness: both masters always valid, slave always ready
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      drive(1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1);
      @(negedge clk);
      check("fair_idle_valid", 0, 32'(mem_valid_o), 32'd0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("fair_imem_ready", k, 32'(imem_ready_o), 32'((k % 2) == 0));
         check("fair_dmem_ready", k, 32'(dmem_ready_o), 32'((k % 2) == 1));
         check("fair_addr",       k, mem_addr_o, ((k % 2) == 0) ? 32'h40 : 32'h80);
      end
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("fair_end_valid", 0, 32'(mem_valid_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
